// File: rtl/ncpu32k_req_collector.sv
// ncpu32k_req_collector
// Requester-side end of a priority one-hot arbitration interface. Per-source request pulses are
// latched into a sticky pending vector that is driven to an arbiter. The arbiter's one-hot grant
// is converted to a binary index and presented on a valid/ready output stage.
//
// Parameters:
//   DW           number of request sources (>= 1)
//   POLARITY_REQ ARB_REQ active level (nonzero = high active)
//   POLARITY_GNT ARB_GNT active level (nonzero = high active)
//   AW           OUT_IDX width, max(1, clog2(DW))
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   SRC_REQ      request event pulses, high active
//   ARB_REQ      pending vector to the arbiter (registered)
//   ARB_GNT      one-hot grant from the arbiter
//   OUT_VALID / OUT_READY / OUT_IDX / OUT_ONEHOT  granted-source output stage
//   BUSY         anything pending or held on the output
//   ERR          sticky illegal-grant flag (NCPU32K_REQ_COLLECTOR_CHECK_EN only)
// Build option:
//   NCPU32K_REQ_COLLECTOR_CHECK_EN  rejects multi-hot and non-pending grants and flags them on ERR.
//   Without it, a multi-hot grant of pending sources is taken as its lowest set bit.

module ncpu32k_req_collector #(
  parameter int DW           = 4,
  parameter int POLARITY_REQ = 1,
  parameter int POLARITY_GNT = 1,
  localparam int AW          = (DW > 1) ? $clog2(DW) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] SRC_REQ,
  output logic [DW-1:0] ARB_REQ,
  input  logic [DW-1:0] ARB_GNT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [AW-1:0] OUT_IDX,
  output logic [DW-1:0] OUT_ONEHOT,
  output logic          BUSY
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
  ,
  output logic          ERR
`endif
);

  typedef enum logic {StIdle, StHold} out_st_e;

  logic [DW-1:0] pending_q, pending_d;
  out_st_e       out_st_q, out_st_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_onehot_q, out_onehot_d;

  logic [DW-1:0] gnt_h;
  logic [DW-1:0] gnt_sel;
  logic [AW-1:0] gnt_idx;
  logic          gnt_nz, gnt_sub, gnt_legal;
  logic          cap_en, take;

  assign gnt_h   = (POLARITY_GNT != 0) ? ARB_GNT : ~ARB_GNT;
  assign gnt_nz  = |gnt_h;
  assign gnt_sub = ~|(gnt_h & ~pending_q);
  assign cap_en  = (out_st_q == StIdle) | OUT_READY;

`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
  logic gnt_onehot;
  logic err_q, err_d;

  assign gnt_onehot = ~|(gnt_h & (gnt_h - DW'(1)));
  assign gnt_sel    = gnt_h;
  assign gnt_legal  = gnt_nz & gnt_sub & gnt_onehot;

  // Grant is only looked at while the output stage can take it.
  always_comb begin
    err_d = err_q | (cap_en & gnt_nz & ~(gnt_sub & gnt_onehot));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR = err_q;
`else
  // Isolate the lowest set bit so a multi-hot grant resolves to a single source.
  assign gnt_sel   = gnt_h & (~gnt_h + DW'(1));
  assign gnt_legal = gnt_nz & gnt_sub;
`endif

  assign take = cap_en & gnt_legal;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < DW; i++) begin
      if (gnt_sel[i]) gnt_idx = gnt_idx | AW'(i);
    end
  end

  always_comb begin
    // Set wins over clear on the same bit.
    pending_d = (pending_q & ~(take ? gnt_sel : '0)) | SRC_REQ;
  end

  always_comb begin
    out_st_d     = out_st_q;
    out_idx_d    = out_idx_q;
    out_onehot_d = out_onehot_q;
    unique case (out_st_q)
      StIdle: begin
        if (take) begin
          out_st_d     = StHold;
          out_idx_d    = gnt_idx;
          out_onehot_d = gnt_sel;
        end
      end
      StHold: begin
        if (take) begin
          out_idx_d    = gnt_idx;
          out_onehot_d = gnt_sel;
        end else if (OUT_READY) begin
          out_st_d = StIdle;
        end
      end
      default: out_st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      out_st_q     <= StIdle;
      out_idx_q    <= '0;
      out_onehot_q <= '0;
    end else begin
      pending_q    <= pending_d;
      out_st_q     <= out_st_d;
      out_idx_q    <= out_idx_d;
      out_onehot_q <= out_onehot_d;
    end
  end

  assign ARB_REQ    = (POLARITY_REQ != 0) ? pending_q : ~pending_q;
  assign OUT_VALID  = (out_st_q == StHold);
  assign OUT_IDX    = out_idx_q;
  assign OUT_ONEHOT = out_onehot_q;
  assign BUSY       = (|pending_q) | (out_st_q == StHold);

endmodule

// File: tb/tb_ncpu32k_req_collector.sv
// Bench for ncpu32k_req_collector: instance A (high-active polarities) driven by a
// lowest-index-first arbiter model with an override for forced grants; instance B
// (low-active polarities) driven by the same arbiter style through inverters.
// Granted indices expected on A are queued when requests are driven and popped on handshakes.

module tb_ncpu32k_req_collector;

  logic clk, rst_n;

  logic [3:0] a_src, a_arb_req, a_arb_gnt, a_onehot;
  logic       a_valid, a_ready, a_busy;
  logic [1:0] a_idx;
  logic [3:0] b_src, b_arb_req, b_arb_gnt, b_onehot;
  logic       b_valid, b_ready, b_busy;
  logic [1:0] b_idx;
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
  logic a_err, b_err;
`endif

  logic       force_en;
  logic [3:0] force_gnt;
  logic [3:0] a_lsb, b_req_h, b_lsb;

  logic [1:0] sb[$];
  int n_cmp, n_err;

  ncpu32k_req_collector #(.DW(4), .POLARITY_REQ(1), .POLARITY_GNT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .SRC_REQ(a_src), .ARB_REQ(a_arb_req), .ARB_GNT(a_arb_gnt),
    .OUT_VALID(a_valid), .OUT_READY(a_ready), .OUT_IDX(a_idx), .OUT_ONEHOT(a_onehot),
    .BUSY(a_busy)
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    , .ERR(a_err)
`endif
  );

  ncpu32k_req_collector #(.DW(4), .POLARITY_REQ(0), .POLARITY_GNT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .SRC_REQ(b_src), .ARB_REQ(b_arb_req), .ARB_GNT(b_arb_gnt),
    .OUT_VALID(b_valid), .OUT_READY(b_ready), .OUT_IDX(b_idx), .OUT_ONEHOT(b_onehot),
    .BUSY(b_busy)
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    , .ERR(b_err)
`endif
  );

  // Lowest-index-first one-hot arbiters.
  always_comb begin
    a_lsb     = a_arb_req & (~a_arb_req + 4'd1);
    a_arb_gnt = force_en ? force_gnt : a_lsb;
    b_req_h   = ~b_arb_req;
    b_lsb     = b_req_h & (~b_req_h + 4'd1);
    b_arb_gnt = ~b_lsb;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard monitor on A's handshakes.
  always @(negedge clk) begin
    logic [1:0] e_idx;
    logic [3:0] e_oh;
    if (rst_n && a_valid && a_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got idx=%0d onehot=%b, required no output", a_idx, a_onehot);
      end else begin
        e_idx = sb.pop_front();
        e_oh  = 4'b0001 << e_idx;
        if (a_idx !== e_idx || a_onehot !== e_oh) begin
          n_err++;
          $display("FAIL sb_output: got idx=%0d onehot=%b, required idx=%0d onehot=%b",
                   a_idx, a_onehot, e_idx, e_oh);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk_sb_empty(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: got %0d outstanding, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (a_valid !== 1'b0 || a_idx !== 2'd0 || a_onehot !== 4'd0 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a_out: got v=%b idx=%0d oh=%b busy=%b, required 0", a_valid, a_idx,
               a_onehot, a_busy);
    end
    n_cmp++;
    if (a_arb_req !== 4'b0000) begin
      n_err++; $display("FAIL reset_a_req: got %b required 0000", a_arb_req);
    end
    n_cmp++;
    if (b_arb_req !== 4'b1111) begin
      n_err++; $display("FAIL reset_b_req: got %b required 1111", b_arb_req);
    end
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_err++; $display("FAIL reset_err: got %b required 0", a_err);
    end
`endif
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_two_sources();
    next(); a_src = 4'b1010; a_ready = 1'b1; sb.push_back(2'd1); sb.push_back(2'd3);
    next(); a_src = 4'b0000;
    smp();
    n_cmp++;
    if (a_arb_req !== 4'b1010 || a_valid !== 1'b0) begin
      n_err++; $display("FAIL t1_n1: got req=%b v=%b required 1010 0", a_arb_req, a_valid);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd1) begin
      n_err++; $display("FAIL t1_n2: got v=%b idx=%0d required 1 1", a_valid, a_idx);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd3) begin
      n_err++; $display("FAIL t1_n3: got v=%b idx=%0d required 1 3", a_valid, a_idx);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL t1_n4: got v=%b busy=%b required 0 0", a_valid, a_busy);
    end
    chk_sb_empty("t1_sb_empty");
  endtask

  task automatic test_backpressure();
    next(); a_src = 4'b1001; a_ready = 1'b0; sb.push_back(2'd0); sb.push_back(2'd3);
    next(); a_src = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      next(); smp();
      n_cmp++;
      if (a_valid !== 1'b1 || a_idx !== 2'd0 || a_onehot !== 4'b0001 || a_arb_req !== 4'b1000) begin
        n_err++;
        $display("FAIL t2_hold%0d: got v=%b idx=%0d oh=%b req=%b required 1 0 0001 1000", i,
                 a_valid, a_idx, a_onehot, a_arb_req);
      end
    end
    next(); a_ready = 1'b1;
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd3) begin
      n_err++; $display("FAIL t2_release: got v=%b idx=%0d required 1 3", a_valid, a_idx);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b0) begin
      n_err++; $display("FAIL t2_idle: got v=%b required 0", a_valid);
    end
    chk_sb_empty("t2_sb_empty");
  endtask

  task automatic test_merge();
    next(); a_ready = 1'b0; a_src = 4'b0001; sb.push_back(2'd0);
    next(); a_src = 4'b0100;
    next(); a_src = 4'b0000;
    next(); a_src = 4'b0100; sb.push_back(2'd2);
    next(); a_src = 4'b0000;
    smp();
    n_cmp++;
    if (a_arb_req !== 4'b0100) begin
      n_err++; $display("FAIL t3_merged_req: got %b required 0100", a_arb_req);
    end
    next(); a_ready = 1'b1;
    for (int i = 0; i < 4; i++) next();
    smp();
    n_cmp++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL t3_merge_done: got v=%b busy=%b required 0 0", a_valid, a_busy);
    end
    chk_sb_empty("t3_merge_sb");
    // Re-pulse on the capture edge must survive the clear.
    next(); a_src = 4'b0100; sb.push_back(2'd2); sb.push_back(2'd2);
    next();
    next(); a_src = 4'b0000;
    smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd2 || a_arb_req !== 4'b0100) begin
      n_err++; $display("FAIL t3_cap1: got v=%b idx=%0d req=%b required 1 2 0100", a_valid,
                        a_idx, a_arb_req);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd2) begin
      n_err++; $display("FAIL t3_cap2: got v=%b idx=%0d required 1 2", a_valid, a_idx);
    end
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b0 || a_busy !== 1'b0) begin
      n_err++; $display("FAIL t3_cap_done: got v=%b busy=%b required 0 0", a_valid, a_busy);
    end
    chk_sb_empty("t3_cap_sb");
  endtask

  task automatic test_low_polarity();
    next(); b_src = 4'b0001;
    next(); b_src = 4'b0000;
    smp();
    n_cmp++;
    if (b_arb_req !== 4'b1110 || b_arb_gnt !== 4'b1110) begin
      n_err++; $display("FAIL t4_req_gnt: got req=%b gnt=%b required 1110 1110", b_arb_req,
                        b_arb_gnt);
    end
    next(); smp();
    n_cmp++;
    if (b_valid !== 1'b1 || b_idx !== 2'd0 || b_onehot !== 4'b0001) begin
      n_err++; $display("FAIL t4_out: got v=%b idx=%0d oh=%b required 1 0 0001", b_valid, b_idx,
                        b_onehot);
    end
    next(); smp();
    n_cmp++;
    if (b_valid !== 1'b0 || b_arb_req !== 4'b1111) begin
      n_err++; $display("FAIL t4_idle: got v=%b req=%b required 0 1111", b_valid, b_arb_req);
    end
  endtask

  task automatic test_multi_hot();
    next(); a_ready = 1'b1; force_en = 1'b1; force_gnt = 4'b0000; a_src = 4'b0110;
    next(); a_src = 4'b0000; force_gnt = 4'b0110; sb.push_back(2'd1); sb.push_back(2'd2);
    smp();
    n_cmp++;
    if (a_arb_req !== 4'b0110 || a_valid !== 1'b0) begin
      n_err++; $display("FAIL t5_pre: got req=%b v=%b required 0110 0", a_arb_req, a_valid);
    end
    next(); force_en = 1'b0;
    smp();
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    n_cmp++;
    if (a_err !== 1'b1 || a_valid !== 1'b0 || a_arb_req !== 4'b0110) begin
      n_err++; $display("FAIL t5_check: got err=%b v=%b req=%b required 1 0 0110", a_err,
                        a_valid, a_arb_req);
    end
`else
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd1 || a_arb_req !== 4'b0100) begin
      n_err++; $display("FAIL t5_lowest: got v=%b idx=%0d req=%b required 1 1 0100", a_valid,
                        a_idx, a_arb_req);
    end
`endif
    for (int i = 0; i < 4; i++) next();
    smp();
    n_cmp++;
    if (a_busy !== 1'b0) begin
      n_err++; $display("FAIL t5_drain: got busy=%b required 0", a_busy);
    end
    chk_sb_empty("t5_sb_empty");
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    n_cmp++;
    if (a_err !== 1'b1) begin
      n_err++; $display("FAIL t5_err_sticky: got %b required 1", a_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    next(); a_ready = 1'b0; a_src = 4'b1000; sb.push_back(2'd3);
    next(); a_src = 4'b0000;
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd3) begin
      n_err++; $display("FAIL t6_pre: got v=%b idx=%0d required 1 3", a_valid, a_idx);
    end
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if (a_valid !== 1'b0 || a_idx !== 2'd0 || a_onehot !== 4'd0 || a_arb_req !== 4'd0 ||
        a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL t6_async: got v=%b idx=%0d oh=%b req=%b busy=%b required all 0", a_valid,
               a_idx, a_onehot, a_arb_req, a_busy);
    end
`ifdef NCPU32K_REQ_COLLECTOR_CHECK_EN
    n_cmp++;
    if (a_err !== 1'b0) begin
      n_err++; $display("FAIL t6_err: got %b required 0", a_err);
    end
`endif
    next(); rst_n = 1'b1; a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      n_cmp++;
      if (a_valid !== 1'b0) begin
        n_err++; $display("FAIL t6_no_replay%0d: got v=%b required 0", i, a_valid);
      end
      next();
    end
    a_src = 4'b0001; sb.push_back(2'd0);
    next(); a_src = 4'b0000;
    next(); smp();
    n_cmp++;
    if (a_valid !== 1'b1 || a_idx !== 2'd0) begin
      n_err++; $display("FAIL t6_new_req: got v=%b idx=%0d required 1 0", a_valid, a_idx);
    end
    next(); next();
    chk_sb_empty("t6_sb_empty");
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    a_src = '0; a_ready = 1'b1; b_src = '0; b_ready = 1'b1;
    force_en = 1'b0; force_gnt = '0;
    test_reset();
    test_two_sources();
    test_backpressure();
    test_merge();
    test_low_polarity();
    test_multi_hot();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
